f4_ram_ctrl: RTL and testbench

F4_RAM_CTRL -- requirements
Module: f4_ram_ctrl

---
 rtl/f4_ram_ctrl.sv | 140 ++++++++++++++
 tb/tb_f4_ram_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f4_ram_ctrl.sv
// F4 frame buffer controller: fills a NUM_WORDS x 256b RAM from a producer, then drains it NUM_PASSES times to a consumer.
// Latency: write is combinational pass-through to the RAM port; read data returns one cycle after issue (RAM read latency).
// Backpressure: in_ready is high only while filling; rd_en gates read issue, returning data is never stalled.
module f4_ram_ctrl #(
    parameter int NUM_WORDS  = 25,
    parameter int NUM_PASSES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [255:0] in_data,
    output logic         in_ready,
    output logic         f4_wr_en,
    output logic [6:0]   f4_waddr,
    output logic [255:0] f4_wdata,
    output logic [6:0]   f4_raddr,
    input  logic [255:0] f4_rdata,
    input  logic         rd_start,
    input  logic         rd_en,
    output logic         rd_valid,
    output logic [255:0] rd_data,
    output logic         rd_last,
    output logic         frame_done,
    output logic [1:0]   state_o
);

    localparam logic [6:0] LAST_WORD = 7'(NUM_WORDS - 1);
    localparam logic [7:0] LAST_PASS = 8'(NUM_PASSES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [6:0] wr_cnt;
    logic [6:0] rd_cnt;
    logic [7:0] pass_cnt;
    logic       issue;
    logic       issue_wrap;
    logic       issue_final;

    // Word-of-pass and end-of-frame flags for the read being issued this cycle.
    assign issue_wrap  = issue && (rd_cnt == LAST_WORD);
    assign issue_final = issue_wrap && (pass_cnt == LAST_PASS);

    assign f4_waddr = wr_cnt;
    assign f4_wdata = in_data;
    assign f4_raddr = rd_cnt;
    assign rd_data  = f4_rdata;
    assign state_o  = state;

    // State register; the unused encoding falls back to IDLE through the next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; the final issue leaves DRAIN at once so its
    // returning word and frame_done coincide with IDLE (buffer already free to refill).
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        f4_wr_en  = 1'b0;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                f4_wr_en = in_valid;
                if (in_valid && (wr_cnt == LAST_WORD)) begin
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (rd_start) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                issue = rd_en;
                if (rd_en && (rd_cnt == LAST_WORD) && (pass_cnt == LAST_PASS)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write address counter: advances per accepted word, clears on the frame's last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
        end else if (f4_wr_en) begin
            if (wr_cnt == LAST_WORD) begin
                wr_cnt <= '0;
            end else begin
                wr_cnt <= wr_cnt + 7'd1;
            end
        end
    end

    // Read address and pass counters: restart on drain entry, wrap per pass, idle at 0 outside DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt   <= '0;
            pass_cnt <= '0;
        end else if ((state == ST_FULL) && rd_start) begin
            rd_cnt   <= '0;
            pass_cnt <= '0;
        end else if (issue) begin
            if (issue_wrap) begin
                rd_cnt   <= '0;
                pass_cnt <= issue_final ? 8'd0 : (pass_cnt + 8'd1);
            end else begin
                rd_cnt <= rd_cnt + 7'd1;
            end
        end
    end

    // Read-return flags track the RAM's one-cycle latency; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rd_valid   <= issue;
            rd_last    <= issue_wrap;
            frame_done <= issue_final;
        end
    end

endmodule

// File: tb/tb_f4_ram_ctrl.sv
// Bench for f4_ram_ctrl: three instances (25x1, 4x3, 1x2 words x passes) against a frame-level model.
// Model tracks fill count, stored words and linear read index; a negedge process compares every cycle.
// Directed scenarios add literal checks on read-back data, pulse counts and reset behaviour.
module tb_f4_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]   rst, in_valid, rd_start, rd_en;
    logic [2:0]   in_ready, f4_wr_en, rd_valid, rd_last, frame_done;
    logic [255:0] in_data    [3];
    logic [255:0] f4_wdata   [3];
    logic [255:0] f4_rdata   [3];
    logic [255:0] rd_data    [3];
    logic [6:0]   f4_waddr   [3];
    logic [6:0]   f4_raddr   [3];
    logic [1:0]   state_o    [3];

    function automatic int nw_of(input int i);
        return (i == 0) ? 25 : (i == 1) ? 4 : 1;
    endfunction
    function automatic int np_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 2;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        f4_ram_ctrl #(.NUM_WORDS(nw_of(g)), .NUM_PASSES(np_of(g))) u_dut (
            .clk(clk), .rst(rst[g]),
            .in_valid(in_valid[g]), .in_data(in_data[g]), .in_ready(in_ready[g]),
            .f4_wr_en(f4_wr_en[g]), .f4_waddr(f4_waddr[g]), .f4_wdata(f4_wdata[g]),
            .f4_raddr(f4_raddr[g]), .f4_rdata(f4_rdata[g]),
            .rd_start(rd_start[g]), .rd_en(rd_en[g]),
            .rd_valid(rd_valid[g]), .rd_data(rd_data[g]), .rd_last(rd_last[g]),
            .frame_done(frame_done[g]), .state_o(state_o[g])
        );
    end

    // RAM with one-cycle read latency per instance
    logic [255:0] ram [3][128];
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (f4_wr_en[i]) ram[i][f4_waddr[i]] <= f4_wdata[i];
            f4_rdata[i] <= ram[i][f4_raddr[i]];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Frame-level model: mode 0 filling, 1 full, 2 draining; m_k is the linear read index.
    int           m_mode [3] = '{0, 0, 0};
    int           m_wr   [3] = '{0, 0, 0};
    int           m_k    [3] = '{0, 0, 0};
    bit           m_pend [3] = '{0, 0, 0};
    bit           m_last [3] = '{0, 0, 0};
    bit           m_done [3] = '{0, 0, 0};
    logic [255:0] m_data [3];
    logic [255:0] m_mem  [3][128];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int nw;
            int np;
            nw = nw_of(i);
            np = np_of(i);
            if (rst[i]) begin
                m_mode[i] = 0; m_wr[i] = 0; m_k[i] = 0; m_pend[i] = 0;
            end else begin
                m_pend[i] = 0;
                if (m_mode[i] == 0) begin
                    if (in_valid[i]) begin
                        m_mem[i][m_wr[i]] = in_data[i];
                        m_wr[i]++;
                        if (m_wr[i] == nw) begin
                            m_wr[i] = 0;
                            m_mode[i] = 1;
                        end
                    end
                end else if (m_mode[i] == 1) begin
                    if (rd_start[i]) begin
                        m_mode[i] = 2;
                        m_k[i] = 0;
                    end
                end else if (rd_en[i]) begin
                    m_pend[i] = 1;
                    m_data[i] = m_mem[i][m_k[i] % nw];
                    m_last[i] = ((m_k[i] % nw) == nw - 1);
                    m_done[i] = (m_k[i] == nw * np - 1);
                    m_k[i]++;
                    if (m_done[i]) m_mode[i] = 0;
                end
            end
        end
    end

    // Per-cycle compare plus bookkeeping of what the DUT delivered
    bit           chk_on = 1'b0;
    int           cur = 0;
    int           n_valid [3] = '{0, 0, 0};
    int           n_last  [3] = '{0, 0, 0};
    int           n_done  [3] = '{0, 0, 0};
    logic [255:0] done_data [3];
    logic [255:0] got_q [$];

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                bit exp_we;
                int exp_ra;
                exp_we = in_valid[i] && (m_mode[i] == 0);
                exp_ra = (m_mode[i] == 2) ? (m_k[i] % nw_of(i)) : 0;
                chk($sformatf("u%0d.state", i), 256'(state_o[i]), 256'(m_mode[i]));
                chk($sformatf("u%0d.in_ready", i), 256'(in_ready[i]), 256'(m_mode[i] == 0));
                chk($sformatf("u%0d.wr_en", i), 256'(f4_wr_en[i]), 256'(exp_we));
                if (exp_we) begin
                    chk($sformatf("u%0d.waddr", i), 256'(f4_waddr[i]), 256'(m_wr[i]));
                    chk($sformatf("u%0d.wdata", i), f4_wdata[i], in_data[i]);
                end
                chk($sformatf("u%0d.raddr", i), 256'(f4_raddr[i]), 256'(exp_ra));
                chk($sformatf("u%0d.rd_valid", i), 256'(rd_valid[i]), 256'(m_pend[i]));
                if (m_pend[i]) begin
                    chk($sformatf("u%0d.rd_data", i), rd_data[i], m_data[i]);
                    chk($sformatf("u%0d.rd_last", i), 256'(rd_last[i]), 256'(m_last[i]));
                    chk($sformatf("u%0d.frame_done", i), 256'(frame_done[i]), 256'(m_done[i]));
                end else begin
                    chk($sformatf("u%0d.frame_done_idle", i), 256'(frame_done[i]), 256'(0));
                end
                if (rd_valid[i]) begin
                    n_valid[i]++;
                    if (rd_last[i]) n_last[i]++;
                    if (i == cur) got_q.push_back(rd_data[i]);
                end
                if (frame_done[i]) begin
                    n_done[i]++;
                    done_data[i] = rd_data[i];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int i, input int n, input int base);
        for (int j = 0; j < n; j++) begin
            in_valid[i] = 1'b1;
            in_data[i]  = 256'(base + j);
            tick();
        end
        in_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i, input bit toggle, input bit hold);
        int c;
        c = 0;
        rd_start[i] = 1'b1;
        tick();
        rd_start[i] = 1'b0;
        while (m_mode[i] == 2 && c < 400) begin
            rd_en[i]    = toggle ? (c % 2 == 0) : 1'b1;
            in_valid[i] = hold && (c < 3);
            in_data[i]  = 256'hDEAD;
            tick();
            c++;
        end
        rd_en[i]    = 1'b0;
        in_valid[i] = 1'b0;
        chk($sformatf("u%0d.drain_bound", i), 256'(m_mode[i] != 2), 256'(1));
        tick();
    endtask

    // Expect got_q[b..b+n-1] == base + (j % nw)
    task automatic chk_words(input string nm, input int b, input int n, input int base, input int nw);
        chk({nm, ".count"}, 256'(got_q.size() - b), 256'(n));
        for (int j = 0; j < n && (b + j) < got_q.size(); j++)
            chk($sformatf("%s.word%0d", nm, j), got_q[b + j], 256'(base + (j % nw)));
    endtask

    initial begin
        int b, v0, l0, d0;
        rst = 3'b111; in_valid = '0; rd_start = '0; rd_en = '0;
        for (int i = 0; i < 3; i++) in_data[i] = '0;
        tick();
        chk_on = 1'b1;
        tick();
        rst = 3'b000;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.rst_state", i), 256'(state_o[i]), 256'(0));
            chk($sformatf("u%0d.rst_in_ready", i), 256'(in_ready[i]), 256'(1));
            chk($sformatf("u%0d.rst_rd_valid", i), 256'(rd_valid[i]), 256'(0));
            chk($sformatf("u%0d.rst_raddr", i), 256'(f4_raddr[i]), 256'(0));
        end

        // 25x1: rd_start ignored in IDLE, fill index data, blocked writes in FULL, single pass
        cur = 0;
        rd_start[0] = 1'b1; tick(); rd_start[0] = 1'b0;
        chk("A.rd_start_idle", 256'(state_o[0]), 256'(0));
        fill(0, 25, 0);
        chk("A.full", 256'(state_o[0]), 256'(1));
        chk("A.ram0", ram[0][0], 256'(0));
        chk("A.ram24", ram[0][24], 256'(24));
        in_valid[0] = 1'b1; in_data[0] = 256'hDEAD;
        tick(); tick();
        chk("A.full_in_ready", 256'(in_ready[0]), 256'(0));
        chk("A.full_wr_en", 256'(f4_wr_en[0]), 256'(0));
        b = got_q.size(); l0 = n_last[0]; d0 = n_done[0];
        drain(0, 1'b0, 1'b1);
        chk_words("A", b, 25, 0, 25);
        chk("A.last_cnt", 256'(n_last[0] - l0), 256'(1));
        chk("A.done_cnt", 256'(n_done[0] - d0), 256'(1));
        chk("A.done_word", done_data[0], 256'(24));
        chk("A.idle_after", 256'(in_ready[0]), 256'(1));

        // 4x3: continuous, then rd_en toggling
        cur = 1;
        fill(1, 4, 100);
        b = got_q.size(); l0 = n_last[1]; d0 = n_done[1];
        drain(1, 1'b0, 1'b0);
        chk_words("B", b, 12, 100, 4);
        chk("B.last_cnt", 256'(n_last[1] - l0), 256'(3));
        chk("B.done_cnt", 256'(n_done[1] - d0), 256'(1));
        chk("B.done_word", done_data[1], 256'(103));
        fill(1, 4, 200);
        b = got_q.size(); d0 = n_done[1];
        drain(1, 1'b1, 1'b0);
        chk_words("C", b, 12, 200, 4);
        chk("C.done_cnt", 256'(n_done[1] - d0), 256'(1));

        // 25x1: reset mid-fill, refill restarts at address 0
        cur = 0;
        fill(0, 10, 500);
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        fill(0, 25, 1000);
        chk("D.full", 256'(state_o[0]), 256'(1));
        chk("D.ram0", ram[0][0], 256'(1000));
        chk("D.ram9", ram[0][9], 256'(1009));
        b = got_q.size();
        drain(0, 1'b0, 1'b0);
        chk_words("D", b, 25, 1000, 25);

        // 25x1: reset after issuing word 7, word 8 in flight is dropped
        fill(0, 25, 2000);
        b = got_q.size(); v0 = n_valid[0]; d0 = n_done[0];
        rd_start[0] = 1'b1; tick(); rd_start[0] = 1'b0;
        rd_en[0] = 1'b1;
        repeat (8) tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0; rd_en[0] = 1'b0;
        chk("E.rd_valid", 256'(rd_valid[0]), 256'(0));
        chk("E.state", 256'(state_o[0]), 256'(0));
        chk("E.in_ready", 256'(in_ready[0]), 256'(1));
        tick(); tick();
        chk_words("E", b, 8, 2000, 25);
        chk("E.valid_cnt", 256'(n_valid[0] - v0), 256'(8));
        chk("E.done_cnt", 256'(n_done[0] - d0), 256'(0));

        // 1x2: every word is last, frame_done on the second
        cur = 2;
        fill(2, 1, 'h77);
        chk("F.full", 256'(state_o[2]), 256'(1));
        b = got_q.size(); l0 = n_last[2]; d0 = n_done[2];
        drain(2, 1'b0, 1'b0);
        chk_words("F", b, 2, 'h77, 1);
        chk("F.last_cnt", 256'(n_last[2] - l0), 256'(2));
        chk("F.done_cnt", 256'(n_done[2] - d0), 256'(1));

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
